// File: rtl/onehot_mux_pipe.sv
// Registered one-hot multiplexer with valid/ready flow control.
// Non-one-hot selects are resolved to the lowest set bit or dropped, and are recorded in sticky error flags.
module onehot_mux_pipe #(
   parameter  int WIDTH = 64,
   parameter  int N     = 8,
   parameter  int CNT_W = 16,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] data_in,
   input  logic [N-1:0]       select,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err_zero,
   output logic               err_multi,
   output logic [CNT_W-1:0]   err_count,
   input  logic               err_clear
);

   logic             sel_zero;
   logic             sel_multi;
   logic [IDX_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_data;
   logic             accept;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [IDX_W-1:0] out_idx_q,   out_idx_d;
   logic             err_zero_q,  err_zero_d;
   logic             err_multi_q, err_multi_d;
   logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Scanning downward lets the lowest set bit win on a multi-hot select.
   always_comb begin
      sel_idx  = '0;
      sel_data = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (select[i]) begin
            sel_idx  = IDX_W'(i);
            sel_data = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   assign sel_zero  = ~|select;
   assign sel_multi = |(select & (select - N'(1)));

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      err_zero_d  = err_zero_q;
      err_multi_d = err_multi_q;
      err_cnt_d   = err_cnt_q;

      // A zero-hot accept carries no data, so it behaves like an idle cycle on the output.
      if (accept && !sel_zero) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_idx_d   = sel_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (err_clear) begin
         err_zero_d  = 1'b0;
         err_multi_d = 1'b0;
         err_cnt_d   = '0;
      end else if (accept && (sel_zero || sel_multi)) begin
         err_zero_d  = err_zero_q  | sel_zero;
         err_multi_d = err_multi_q | sel_multi;
         err_cnt_d   = sat_inc(err_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         err_zero_q  <= 1'b0;
         err_multi_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         err_zero_q  <= err_zero_d;
         err_multi_q <= err_multi_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign err_zero  = err_zero_q;
   assign err_multi = err_multi_q;
   assign err_count = err_cnt_q;

endmodule

// File: doc/onehot_mux_pipe.md
Name: onehot_mux_pipe

Overview:
- Parametrised successor to the fixed 1/2/4/8-way one-hot muxes. Supports any channel count N from 1 to 32 and arbitrary WIDTH.
- Registered output with valid/ready flow control, so it can sit on a streaming datapath between shell arbitration logic and application ports.
- Detects select vectors that are not one-hot (zero-hot or multi-hot), handles them deterministically, and reports them through sticky flags and a saturating error counter.

Parameters:
- WIDTH, 64, data width per channel in bits (>=1).
- N, 8, number of input channels (1..32).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  N*WIDTH  flattened channels; channel i occupies bits [i*WIDTH +: WIDTH].
- select  input  N  one-hot channel select, qualified by in_valid.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  WIDTH  selected channel data (registered).
- out_idx  output  max(1,$clog2(N))  binary index of the selected channel (registered).
- out_valid  output  1  out_data/out_idx hold a beat.
- out_ready  input  1  downstream accepts the beat.
- err_zero  output  1  sticky: a zero-hot select was accepted.
- err_multi  output  1  sticky: a multi-hot select was accepted.
- err_count  output  CNT_W  saturating count of accepted non-one-hot beats.
- err_clear  input  1  clears err_zero, err_multi and err_count.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_idx=0, err_zero=0, err_multi=0, err_count=0. in_ready=1 in the cycle after reset deasserts.
- in_ready = !out_valid || out_ready, combinational. No combinational path from in_valid or select to in_ready.
- Accept condition: in_valid && in_ready.
- Select decode:
  - Exactly one bit set: index = that bit's position.
  - Multi-hot: index = lowest set bit.
  - Zero-hot: no valid index.
- Accept with one-hot or multi-hot select:
  - out_data <= data_in[index*WIDTH +: WIDTH]; out_idx <= index; out_valid <= 1.
  - Latency from accept to out_valid is 1 cycle.
- Accept with zero-hot select:
  - The beat is dropped. out_valid falls to 0 if the current beat drains this cycle; otherwise it holds.
  - out_data and out_idx hold their values.
- Output hold: when out_valid && !out_ready, out_data and out_idx hold stable and no new beat is accepted.
- Throughput: 1 beat/cycle while out_ready is held high.
- Drain with no accept: out_valid && out_ready && !(in_valid && in_ready) -> out_valid <= 0.
- Error tracking:
  - err_zero / err_multi set on the cycle after the offending accept and stay set until cleared.
  - err_count increments by 1 per accepted non-one-hot beat and saturates at 2^CNT_W-1.
  - Non-accepted beats (in_ready=0) never affect errors.
- err_clear takes priority over same-cycle error events:
  - flags <= 0 and count <= 0.
  - The simultaneous event is lost.
- N==1: select[0]=1 passes data; select[0]=0 counts as zero-hot. out_idx is a constant 1-bit 0.
- Reset mid-transfer discards any held beat; no output beat appears after reset.
- select values outside [N-1:0] do not exist (the port is exactly N bits wide).

Test Plan:
- Reset and pass-through: N=8, WIDTH=64, channel i = 64'h1000+i, out_ready=1; select=8'h20 held for 3 cycles -> out_valid=1 from next cycle, out_data=64'h1005, out_idx=5, 1 beat/cycle, no errors.
- Backpressure: out_ready=0 after first beat with select=8'h01, then select=8'h80 presented -> in_ready=0, out_data stays 64'h1000 for 4 cycles; release out_ready -> next cycle out_data=64'h1007, out_idx=7.
- Multi-hot: select=8'b0010_1100 accepted -> out_idx=2, out_data=64'h1002, err_multi=1, err_count=1, err_zero=0.
- Zero-hot: out_valid=0, select=8'h00 accepted -> out_valid remains 0, err_zero=1, err_count increments; then select=8'h02 -> out_data=64'h1001.
- Saturation and clear: CNT_W=2, five zero-hot beats -> err_count=3; err_clear together with a sixth zero-hot beat -> all error outputs 0 the next cycle.
- Parameter sweep: N in {1,2,3,5,32}, WIDTH in {1,37}, random one-hot selects with random out_ready -> scoreboard matches every beat, no beat lost or duplicated, reset asserted mid-stream leaves out_valid=0.
